mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with a fixed, parameterised
// number of wait cycles before each response. Word-addressed 32-bit storage with
// per-byte write enables.
// Optional build macro MEM_RESPONDER_ERRCHK_EN: flags misaligned or out-of-range
// requests as errors instead of aliasing the word index modulo DEPTH.

module mem_responder #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        en_q;
   logic        cap_we_q;
   logic [31:0] cap_addr_q;
   logic [31:0] cap_wdata_q;
   logic [3:0]  cap_be_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic [AW-1:0] word_idx;
   logic          err_c;

   assign accept     = req_valid & req_ready;
   assign enter_resp = (state_d == StResp) && (state_q != StResp);

   // Access operands: with WAIT=0 the array is touched on the accept edge itself,
   // so the live request is used; otherwise the captured copy is used.
   always_comb begin
      acc_we    = cap_we_q;
      acc_addr  = cap_addr_q;
      acc_wdata = cap_wdata_q;
      acc_be    = cap_be_q;
      if (state_q == StIdle) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

   assign word_idx = AW'({2'b00, acc_addr[31:2]} % DEPTH);

`ifdef MEM_RESPONDER_ERRCHK_EN
   assign err_c = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^acc_addr[1:0];
   assign err_c           = 1'b0;
`endif

   // State register; the enable flop delays req_ready by one cycle after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= 1'b1;
      end
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (WAIT == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StBusy;
                  cnt_d   = 4'(WAIT - 1);
               end
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      req_ready = (state_q == StIdle) && en_q;
      rsp_valid = (state_q == StResp);
      rsp_rdata = (state_q == StResp) ? rdata_q : 32'd0;
      rsp_err   = (state_q == StResp) && err_q;
   end

   // Request capture on the accept edge; BUSY/RESP requests are never captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we_q    <= 1'b0;
         cap_addr_q  <= 32'd0;
         cap_wdata_q <= 32'd0;
         cap_be_q    <= 4'd0;
      end else if (accept) begin
         cap_we_q    <= req_we;
         cap_addr_q  <= req_addr;
         cap_wdata_q <= req_wdata;
         cap_be_q    <= req_be;
      end
   end

   // Response data/error latched on the edge entering RESP, held until handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (acc_we || err_c) ? 32'd0 : mem[word_idx];
         err_q   <= err_c;
      end
   end

   // Storage array: not reset, byte-masked store on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_we && !err_c) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against a byte-level reference model of the storage.

module tb_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WAIT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference storage with per-byte "has been written" flags.
   logic [31:0] m_mem   [DEPTH];
   logic [3:0]  m_known [DEPTH];

   mem_responder #(
      .DEPTH(DEPTH),
      .WAIT (WAIT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_be   (req_be),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Model: compute expected response and update the reference storage.
   function automatic void model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] exp_rd, output logic [31:0] mask,
                                 output logic exp_err);
      int unsigned idx;
      idx     = addr >> 2;
      exp_err = 1'b0;
      exp_rd  = 32'd0;
      mask    = 32'hFFFF_FFFF;
`ifdef MEM_RESPONDER_ERRCHK_EN
      if ((addr % 4) != 0 || idx >= DEPTH) exp_err = 1'b1;
`else
      idx = idx % DEPTH;
`endif
      if (exp_err) return;
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
               m_known[idx][b]      = 1'b1;
            end
         end
      end else begin
         exp_rd = m_mem[idx];
         mask   = 32'd0;
         for (int b = 0; b < 4; b++) begin
            if (m_known[idx][b]) mask[8*b +: 8] = 8'hFF;
         end
      end
   endfunction

   // One full request/response with latency, stall and handshake checks.
   task automatic xact(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input logic intrude, output logic [31:0] rd, output logic err);
      int n;
      @(negedge clk);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_wait: req_ready=%b required 1", name, req_ready);
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || n != WAIT + 1) begin
         n_fail++;
         $display("FAIL %s latency: rsp_valid=%b after %0d cycles, required 1 after %0d",
                  name, rsp_valid, n, WAIT + 1);
      end
      rd  = rsp_rdata;
      err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         if (intrude) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = addr;
            req_wdata = ~wdata;
            req_be    = 4'hF;
         end
         @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== err || req_ready !== 1'b0)
         begin
            n_fail++;
            $display("FAIL %s stall%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                     name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd, err);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s handshake: rsp_valid=%b req_ready=%b required 0/1",
                  name, rsp_valid, req_ready);
      end
   endtask

   // Transaction plus model comparison.
   task automatic txn(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic intrude, output logic [31:0] rd, output logic err);
      logic [31:0] exp_rd, mask;
      logic        exp_err;
      xact(name, we, addr, wdata, be, hold, intrude, rd, err);
      model(we, addr, wdata, be, exp_rd, mask, exp_err);
      n_cmp++;
      if (err !== exp_err || (rd & mask) !== (exp_rd & mask)) begin
         n_fail++;
         $display("FAIL %s model: rdata=%h err=%b required %h/%b (mask %h)",
                  name, rd, err, exp_rd, exp_err, mask);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      req_be    = 4'd0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
      begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      logic        err;
      txn("basic_store", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, err);
      txn("basic_load", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL basic_value: rdata=%h required deadbeef", rd);
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd;
      logic        err;
      txn("be_full", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 1'b0, rd, err);
      txn("be_partial", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, 1'b0, rd, err);
      txn("be_load", 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_fail++;
         $display("FAIL be_value: rdata=%h required 11bb33dd", rd);
      end
      txn("be_zero", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, rd, err);
      txn("be_zero_load", 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_fail++;
         $display("FAIL be_zero_value: rdata=%h required 11bb33dd", rd);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      logic        err;
      txn("stall_init", 1'b1, 32'h30, 32'h1234_5678, 4'hF, 0, 1'b0, rd, err);
      txn("stall_load", 1'b0, 32'h30, 32'h0, 4'h0, 5, 1'b1, rd, err);
      txn("stall_store", 1'b1, 32'h34, 32'h0F0F_0F0F, 4'hF, 5, 1'b1, rd, err);
      txn("stall_check30", 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL stall_ignored30: rdata=%h required 12345678", rd);
      end
      txn("stall_check34", 1'b0, 32'h34, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h0F0F_0F0F) begin
         n_fail++;
         $display("FAIL stall_ignored34: rdata=%h required 0f0f0f0f", rd);
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] rd;
      logic        err;
      txn("rb_init", 1'b1, 32'h40, 32'h0000_0055, 4'hF, 0, 1'b0, rd, err);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'hFFFF_FFFF;
      req_be    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b0;
      #1;
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
      begin
         n_fail++;
         $display("FAIL rb_in_reset: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rb_release: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
      end
      txn("rb_load", 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h0000_0055) begin
         n_fail++;
         $display("FAIL rb_value: rdata=%h required 00000055", rd);
      end
   endtask

   task automatic test_config();
      logic [31:0] rd;
      logic        err;
`ifdef MEM_RESPONDER_ERRCHK_EN
      txn("cfg_w0", 1'b1, 32'h0, 32'hCAFE_0000, 4'hF, 0, 1'b0, rd, err);
      txn("cfg_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (err !== 1'b1 || rd !== 32'd0) begin
         n_fail++;
         $display("FAIL cfg_misalign_err: err=%b rdata=%h required 1/00000000", err, rd);
      end
      txn("cfg_range", 1'b1, 32'h1000, 32'h0000_0099, 4'hF, 0, 1'b0, rd, err);
      n_cmp++;
      if (err !== 1'b1 || rd !== 32'd0) begin
         n_fail++;
         $display("FAIL cfg_range_err: err=%b rdata=%h required 1/00000000", err, rd);
      end
      txn("cfg_w0_load", 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'hCAFE_0000 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_w0_kept: rdata=%h err=%b required cafe0000/0", rd, err);
      end
`else
      txn("cfg_wrap_store", 1'b1, 32'h1000, 32'h0000_0099, 4'hF, 0, 1'b0, rd, err);
      txn("cfg_wrap_load", 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, err);
      n_cmp++;
      if (rd !== 32'h0000_0099 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_wrap: rdata=%h err=%b required 00000099/0", rd, err);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] rd, addr;
      logic        err;
      for (int t = 0; t < 80; t++) begin
         addr = 32'($urandom_range(0, 31)) << 2;
         if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) addr = addr + (DEPTH * 4) * $urandom_range(1, 3);
         txn("random", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd, err);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 4'h0;
      test_reset();
      test_basic();
      test_byte_enable();
      test_stall();
      test_reset_busy();
      test_config();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
